// File: rtl/ln_pkg.sv
// Shared types and constants for the ln range-reduction front end (ln_arg_reduce).
package ln_pkg;

  typedef enum logic [2:0] {
    CLS_NORMAL = 3'd0,
    CLS_ZERO   = 3'd1,
    CLS_NEG    = 3'd2,
    CLS_INF    = 3'd3,
    CLS_NAN    = 3'd4
  } ln_class_t;

  localparam int          FP_EXP_BIAS = 127;
  localparam int          FP_FRAC_W   = 23;
  localparam logic [22:0] SQRT2_FRAC  = 23'h3504F3;

  typedef struct packed {
    logic signed [8:0] k;
    ln_class_t         cls;
  } ln_tag_t;

  // Leading-zero count over 24 bits; returns 24 for an all-zero word.
  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd24;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(23 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/ln_tag_fifo.sv
// Circular tag FIFO holding {k, class} for each operation in flight through the core.
// Pointers wrap at DEPTH-1 so any DEPTH works; push while full is allowed when a pop happens too.
module ln_tag_fifo
  import ln_pkg::*;
#(
  parameter int DEPTH = 80
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  logic    pop,
  input  ln_tag_t wdata,
  output ln_tag_t rdata,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  ln_tag_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ln_arg_reduce.sv
// Range reduction y = 2^k * m ahead of ln_fast_core, re-pairing k/class with each core result.
// Optional LN_CENTER_RANGE_EN centres m around 1 (m >= sqrt2 -> k+1, x = m/2-1).
module ln_arg_reduce
  import ln_pkg::*;
#(
  parameter int DEPTH = 80
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              y_valid,
  output logic              y_ready,
  input  logic [31:0]       y,
  output logic [31:0]       x,
  output logic              start,
  input  logic [31:0]       core_ln,
  input  logic              core_done,
  input  logic              core_error,
  output logic              res_valid,
  output logic [31:0]       res_ln_m,
  output logic signed [8:0] res_k,
  output logic [2:0]        res_class,
  output logic              res_error,
  output logic              err_unexpected
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]     outstanding;
  logic              accept;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  ln_tag_t           tag_q;
  ln_tag_t           tag_rd;

  logic [7:0]        y_e;
  logic [22:0]       y_f;
  ln_class_t         cls_d;

  logic              s1_valid;
  ln_class_t         s1_cls;
  logic signed [8:0] s1_k;
  logic [22:0]       s1_f;

  logic [4:0]        lz;
  logic [31:0]       x_d;
  logic signed [8:0] k_d;

  assign y_ready = (outstanding < CW'(DEPTH));
  assign accept  = y_valid && y_ready;
  assign pop     = core_done && !fifo_empty;

  // Only popped results retire an operation; a stray core_done leaves the count alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign y_e = y[30:23];
  assign y_f = y[FP_FRAC_W-1:0];

  always_comb begin
    cls_d = CLS_NORMAL;
    if (y_e == 8'hFF && y_f != '0) cls_d = CLS_NAN;
    else if (y_e == 8'h00)         cls_d = CLS_ZERO;
    else if (y[31])                cls_d = CLS_NEG;
    else if (y_e == 8'hFF)         cls_d = CLS_INF;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_cls   <= CLS_NORMAL;
      s1_k     <= '0;
      s1_f     <= '0;
    end else begin
      s1_valid <= accept;
      s1_cls   <= cls_d;
      s1_k     <= $signed({1'b0, y_e}) - 9'(FP_EXP_BIAS);
      s1_f     <= y_f;
    end
  end

`ifdef LN_CENTER_RANGE_EN
  logic [23:0] g;
  logic [4:0]  lzg;
  assign g   = 24'h800000 - {1'b0, s1_f};
  assign lzg = lzc24(g);
`endif

  // x = m-1 renormalised: the leading one of f becomes the hidden bit, so the result is exact.
  always_comb begin
    lz  = lzc24({s1_f, 1'b1});
    x_d = '0;
    k_d = s1_k;
    if (s1_cls != CLS_NORMAL) begin
      k_d = '0;
    end else if (s1_f != '0) begin
      x_d = {1'b0, 8'(8'd126 - {3'b000, lz}), 23'(s1_f << (lz + 5'd1))};
    end
`ifdef LN_CENTER_RANGE_EN
    if (s1_cls == CLS_NORMAL && s1_f >= SQRT2_FRAC) begin
      k_d = s1_k + 9'sd1;
      x_d = {1'b1, 8'(8'd126 - {3'b000, lzg}), 23'(g << lzg)};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start <= 1'b0;
      x     <= '0;
      tag_q <= '0;
    end else begin
      start     <= s1_valid;
      x         <= s1_valid ? x_d : '0;
      tag_q.k   <= k_d;
      tag_q.cls <= s1_cls;
    end
  end

  ln_tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (start),
    .pop   (pop),
    .wdata (tag_q),
    .rdata (tag_rd),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid      <= 1'b0;
      res_ln_m       <= '0;
      res_k          <= '0;
      res_class      <= '0;
      res_error      <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      res_valid <= pop;
      if (pop) begin
        res_ln_m  <= core_ln;
        res_error <= core_error;
        res_k     <= tag_rd.k;
        res_class <= tag_rd.cls;
      end
      if (core_done && fifo_empty) err_unexpected <= 1'b1;
    end
  end

  // Full is unreachable while outstanding <= DEPTH; kept visible for debug probing.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_ln_arg_reduce.sv
// Bench for ln_arg_reduce: real-number reference model plus a 75-cycle behavioural core.
module tb_ln_arg_reduce;
  localparam int DEPTH    = 80;
  localparam int CORE_LAT = 75;

  logic        clk = 1'b0, rst_n = 1'b0, y_valid = 1'b0, y_ready;
  logic [31:0] y = '0, x;
  logic        start;
  logic [31:0] core_ln;
  logic        core_done, core_error;
  logic        res_valid;
  logic [31:0] res_ln_m;
  logic [8:0]  res_k;
  logic [2:0]  res_class;
  logic        res_error, err_unexpected;

  ln_arg_reduce #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .y_valid(y_valid), .y_ready(y_ready), .y(y), .x(x),
    .start(start), .core_ln(core_ln), .core_done(core_done), .core_error(core_error),
    .res_valid(res_valid), .res_ln_m(res_ln_m), .res_k(res_k), .res_class(res_class),
    .res_error(res_error), .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] x; int k; int cls; int acc; } exp_t;
  typedef struct { logic [31:0] ln; logic err; int cyc; } iss_t;

  exp_t xq[$], tq[$];
  iss_t iq[$];
  int   pend[$];
  int   checks = 0, failures = 0, cyc = 0, acc_cnt = 0, res_cnt = 0, coin_cnt = 0;
  bit   core_en = 1'b0, man_counted = 1'b0, dir_use = 1'b0;
  exp_t dir_e;
  logic        cm_done = 1'b0, cm_err = 1'b0, man_done = 1'b0, man_err = 1'b0;
  logic [31:0] cm_ln = '0, man_ln = '0;

  assign core_done  = cm_done | man_done;
  assign core_ln    = man_done ? man_ln : cm_ln;
  assign core_error = man_done ? man_err : cm_err;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] sp_bits(input real r);
    logic [63:0] b;
    int ee;
    if (r == 0.0) return 32'h0;
    b  = $realtobits(r);
    ee = int'(b[62:52]) - 1023 + 127;
    return {b[63], ee[7:0], b[51:29]};
  endfunction

  // Reference: classify, then m-1 (or m/2-1 when centring) computed in real arithmetic.
  function automatic exp_t model(input logic [31:0] v);
    exp_t e;
    int ex;
    logic [22:0] f;
    real r, xr;
    ex = int'(v[30:23]);
    f  = v[22:0];
    e.x = '0; e.k = 0; e.acc = 0; e.cls = 0;
    if (ex == 255 && f != 0) e.cls = 4;
    else if (ex == 0)        e.cls = 1;
    else if (v[31])          e.cls = 2;
    else if (ex == 255)      e.cls = 3;
    else begin
      e.k = ex - 127;
      r   = real'(int'(f)) / 8388608.0;
      xr  = r;
`ifdef LN_CENTER_RANGE_EN
      if (f >= 23'h3504F3) begin
        xr  = (1.0 + r) / 2.0 - 1.0;
        e.k = e.k + 1;
      end
`endif
      e.x = sp_bits(xr);
    end
    return e;
  endfunction

  function automatic logic [31:0] gen_y();
    logic [31:0] v;
    int r;
    r = int'($urandom_range(0, 19));
    v = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
    case (r)
      0: v[22:0] = 23'h3504F3;
      1: v[22:0] = 23'h3504F2;
      2: v[22:0] = 23'h0;
      3: v[22:0] = 23'h7FFFFF;
      4: v[30:23] = 8'd1;
      5: v[30:23] = 8'd254;
      6: v[31] = 1'b1;
      7: v[30:23] = 8'd0;
      8: v[30:23] = 8'hFF;
      9: begin v[30:23] = 8'hFF; v[22:0] = 23'h0; end
      10: v = 32'h80000000;
      default: ;
    endcase
    return v;
  endfunction

  always @(posedge clk) cyc = cyc + 1;

  // Behavioural core: each launch answers CORE_LAT cycles later with a random result.
  always @(posedge clk) begin
    #1;
    cm_done = 1'b0;
    if (!rst_n) pend.delete();
    else if (pend.size() > 0 && pend[0] == cyc) begin
      void'(pend.pop_front());
      cm_done = 1'b1;
      cm_ln   = $urandom;
      cm_err  = ($urandom_range(0, 7) == 0);
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    iss_t r;
    if (rst_n) begin
      if (y_valid && y_ready) begin
        e = dir_use ? dir_e : model(y);
        e.acc = cyc;
        xq.push_back(e);
        tq.push_back(e);
        acc_cnt++;
        if (core_done) coin_cnt++;
      end
      if (start) begin
        if (xq.size() == 0) check_eq("start_unexp", 32'(start), 32'd0);
        else begin
          e = xq.pop_front();
          check_eq("x", x, e.x);
          check_eq("start_lat", 32'(cyc), 32'(e.acc + 2));
          if (core_en) pend.push_back(cyc + CORE_LAT);
        end
      end
      if (core_done && (cm_done || man_counted)) iq.push_back('{core_ln, core_error, cyc});
      if (res_valid) begin
        if (tq.size() == 0 || iq.size() == 0) check_eq("res_unexp", 32'(res_valid), 32'd0);
        else begin
          e = tq.pop_front();
          r = iq.pop_front();
          check_eq("res_k", 32'($signed(res_k)), 32'(e.k));
          check_eq("res_class", 32'(res_class), 32'(e.cls));
          check_eq("res_ln_m", res_ln_m, r.ln);
          check_eq("res_error", 32'(res_error), 32'(r.err));
          check_eq("res_lat", 32'(cyc), 32'(r.cyc + 1));
          res_cnt++;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; y_valid = 1'b0; man_done = 1'b0;
    pend.delete(); xq.delete(); tq.delete(); iq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    check_eq({tag, "_y_ready"}, 32'(y_ready), 32'd1);
    check_eq({tag, "_start"}, 32'(start), 32'd0);
    check_eq({tag, "_x"}, x, 32'd0);
    check_eq({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check_eq({tag, "_res_ln_m"}, res_ln_m, 32'd0);
    check_eq({tag, "_res_k"}, 32'(res_k), 32'd0);
    check_eq({tag, "_res_class"}, 32'(res_class), 32'd0);
    check_eq({tag, "_res_error"}, 32'(res_error), 32'd0);
    check_eq({tag, "_err_unexp"}, 32'(err_unexpected), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_done(input bit counted);
    man_counted = counted;
    man_ln      = $urandom;
    man_err     = 1'b1;
    man_done    = 1'b1;
    @(posedge clk); #1;
    man_done    = 1'b0;
    @(negedge clk);
    man_counted = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] v);
    int guard;
    guard = 0;
    y = v; y_valid = 1'b1;
    @(negedge clk);
    while (!y_ready && guard < 200) begin @(negedge clk); guard++; end
    check_eq("send_ready", 32'(y_ready), 32'd1);
    @(posedge clk); #1;
    y_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && tq.size() > 0; i++) @(posedge clk);
    #1;
    check_eq("drain_left", 32'(tq.size()), 32'd0);
  endtask

  task automatic stream(input int n);
    int i, cycles;
    bit took;
    i = 0; cycles = 0;
    y = gen_y(); y_valid = 1'b1;
    while (i < n && cycles < 4 * n) begin
      @(negedge clk); took = y_ready;
      @(posedge clk); #1; cycles++;
      if (took) begin i++; if (i < n) y = gen_y(); end
    end
    y_valid = 1'b0;
    check_eq("stream_count", 32'(i), 32'(n));
    check_eq("stream_no_stall", 32'(cycles), 32'(n));
  endtask

  logic [31:0] dir_y[9], dir_xv[9];
  int          dir_k[9], dir_c[9];
  int          base;

  initial begin
    dir_y[0] = 32'h3F800000; dir_xv[0] = 32'h00000000; dir_k[0] = 0; dir_c[0] = 0;
`ifdef LN_CENTER_RANGE_EN
    dir_y[1] = 32'h40400000; dir_xv[1] = 32'hBE800000; dir_k[1] = 2; dir_c[1] = 0;
    dir_y[2] = 32'h3FE00000; dir_xv[2] = 32'hBE000000; dir_k[2] = 1; dir_c[2] = 0;
`else
    dir_y[1] = 32'h40400000; dir_xv[1] = 32'h3F000000; dir_k[1] = 1; dir_c[1] = 0;
    dir_y[2] = 32'h3FE00000; dir_xv[2] = 32'h3F400000; dir_k[2] = 0; dir_c[2] = 0;
`endif
    dir_y[3] = 32'hBF800000; dir_xv[3] = 32'h0; dir_k[3] = 0; dir_c[3] = 2;
    dir_y[4] = 32'h80000000; dir_xv[4] = 32'h0; dir_k[4] = 0; dir_c[4] = 1;
    dir_y[5] = 32'h00000001; dir_xv[5] = 32'h0; dir_k[5] = 0; dir_c[5] = 1;
    dir_y[6] = 32'h7F800000; dir_xv[6] = 32'h0; dir_k[6] = 0; dir_c[6] = 3;
    dir_y[7] = 32'hFFC00000; dir_xv[7] = 32'h0; dir_k[7] = 0; dir_c[7] = 4;
    dir_y[8] = 32'h3FB504F3; dir_xv[8] = model(32'h3FB504F3).x; dir_k[8] = model(32'h3FB504F3).k; dir_c[8] = 0;

    // Stray core_done straight after reset
    do_reset();
    check_reset_state("rst");
    pulse_done(1'b0);
    repeat (3) @(posedge clk); #1;
    check_eq("stray_err_flag", 32'(err_unexpected), 32'd1);
    check_eq("stray_no_res", 32'(res_cnt), 32'd0);
    do_reset();
    check_reset_state("rst2");

    // Directed operands through the behavioural core
    core_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      dir_e   = '{dir_xv[i], dir_k[i], dir_c[i], 0};
      dir_use = 1'b1;
      send(dir_y[i]);
      dir_use = 1'b0;
    end
    drain();
    check_eq("dir_res_cnt", 32'(res_cnt), 32'd9);

    // Back-to-back random stream
    base = res_cnt; coin_cnt = 0;
    stream(200);
    drain();
    check_eq("stream_res_cnt", 32'(res_cnt - base), 32'd200);
    check_eq("stream_coincide", 32'(coin_cnt >= 100), 32'd1);

    // Credit limit with a silent core
    do_reset();
    core_en = 1'b0; acc_cnt = 0; base = res_cnt;
    y_valid = 1'b1; y = gen_y();
    repeat (100) begin @(posedge clk); #1; y = gen_y(); end
    @(negedge clk);
    check_eq("credit_accepts", 32'(acc_cnt), 32'(DEPTH));
    check_eq("credit_ready_low", 32'(y_ready), 32'd0);
    @(posedge clk); #1;
    pulse_done(1'b1);
    repeat (6) @(posedge clk); #1;
    check_eq("credit_one_more", 32'(acc_cnt), 32'(DEPTH + 1));
    check_eq("credit_one_res", 32'(res_cnt - base), 32'd1);
    y_valid = 1'b0;

    // Reset in the middle of a stream drops every tag
    do_reset();
    core_en = 1'b1; y_valid = 1'b1;
    repeat (30) begin y = gen_y(); @(posedge clk); #1; end
    do_reset();
    check_reset_state("mid_rst");
    base = res_cnt;
    pulse_done(1'b0);
    repeat (90) @(posedge clk); #1;
    check_eq("mid_rst_err_flag", 32'(err_unexpected), 32'd1);
    check_eq("mid_rst_no_res", 32'(res_cnt - base), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
